// File: rtl/tm1637_ctrl.sv
// TM1637 display refresh engine: sends the command, address+digits and display-control frames
// on the two-wire bus, one protocol step per divided tick, and flags missing device ACKs.
module tm1637_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 250
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [8*NUM_DIGITS-1:0] digits,
    input  logic [2:0]              brightness,
    input  logic                    display_on,
    output logic                    ready,
    output logic                    done,
    output logic                    ack_err,
    output logic                    tm1637_clk,
    output logic                    tm1637_dio_out,
    output logic                    tm1637_dio_oe,
    input  logic                    tm1637_dio_in,
    output logic                    tm1637_vcc,
    output logic [6:0]              debug_step_id
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE} state_t;

    state_t                  state_reg, state_next;
    logic [DIV_W-1:0]        div_reg;
    logic [1:0]              phase_reg, phase_next;
    logic [2:0]              bit_reg, bit_next;
    logic [2:0]              byte_reg, byte_next;
    logic [1:0]              frame_reg, frame_next;
    logic [6:0]              step_reg, step_next;
    logic                    ack_err_reg, ack_err_next;
    logic [8*NUM_DIGITS-1:0] digits_reg;
    logic [7:0]              f3_reg;
    logic                    clk_reg, oe_reg, out_reg;
    logic                    clk_cmb, oe_cmb, out_cmb;
    logic                    busy, tick, accept, last_byte;
    logic [7:0]              cur_byte;
    logic [7:0]              digit_arr [NUM_DIGITS];

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_arr[gi] = digits_reg[8*gi +: 8];
    end

    assign busy   = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign tick   = busy && (div_reg == DIV_LAST);
    assign accept = start && (state_reg == S_IDLE);

    always_comb begin
        cur_byte = 8'h40;
        case (frame_reg)
            2'd0: cur_byte = 8'h40;
            2'd1: begin
                cur_byte = 8'hC0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (byte_reg == 3'(i + 1)) cur_byte = digit_arr[i];
                end
            end
            default: cur_byte = f3_reg;
        endcase
    end

    assign last_byte = (frame_reg == 2'd1) ? (byte_reg == 3'(NUM_DIGITS)) : 1'b1;

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        bit_next     = bit_reg;
        byte_next    = byte_reg;
        frame_next   = frame_reg;
        step_next    = step_reg;
        ack_err_next = ack_err_reg;
        clk_cmb      = 1'b1;
        oe_cmb       = 1'b0;
        out_cmb      = 1'b0;

        if (tick) begin
            if (state_reg == S_STOP && phase_reg == 2'd2) step_next = 7'd0;
            else if (step_reg != 7'd127)                 step_next = step_reg + 7'd1;
        end

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next   = S_START;
                    phase_next   = 2'd0;
                    bit_next     = 3'd0;
                    byte_next    = 3'd0;
                    frame_next   = 2'd0;
                    step_next    = 7'd0;
                    ack_err_next = 1'b0;
                end
            end
            S_START: begin
                oe_cmb = 1'b1;
                if (tick) begin
                    state_next = S_BIT;
                    phase_next = 2'd0;
                    bit_next   = 3'd0;
                end
            end
            S_BIT: begin
                clk_cmb = phase_reg[0];
                oe_cmb  = 1'b1;
                out_cmb = cur_byte[bit_reg];
                if (tick) begin
                    if (!phase_reg[0]) begin
                        phase_next = 2'd1;
                    end else if (bit_reg == 3'd7) begin
                        state_next = S_ACK;
                        phase_next = 2'd0;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        phase_next = 2'd0;
                    end
                end
            end
            S_ACK: begin
                clk_cmb = phase_reg[0];
                if (tick) begin
                    if (!phase_reg[0]) begin
                        phase_next = 2'd1;
                    end else begin
                        // A high DIO on the ACK clock means the device did not pull it low.
                        if (tm1637_dio_in) ack_err_next = 1'b1;
                        phase_next = 2'd0;
                        if (last_byte) begin
                            state_next = S_STOP;
                        end else begin
                            state_next = S_BIT;
                            byte_next  = byte_reg + 3'd1;
                            bit_next   = 3'd0;
                        end
                    end
                end
            end
            S_STOP: begin
                clk_cmb = (phase_reg != 2'd0);
                oe_cmb  = (phase_reg != 2'd2);
                if (tick) begin
                    if (phase_reg != 2'd2) begin
                        phase_next = phase_reg + 2'd1;
                    end else if (frame_reg == 2'd2) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_START;
                        frame_next = frame_reg + 2'd1;
                        byte_next  = 3'd0;
                        phase_next = 2'd0;
                    end
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            div_reg     <= '0;
            phase_reg   <= 2'd0;
            bit_reg     <= 3'd0;
            byte_reg    <= 3'd0;
            frame_reg   <= 2'd0;
            step_reg    <= 7'd0;
            ack_err_reg <= 1'b0;
            digits_reg  <= '0;
            f3_reg      <= 8'h80;
            clk_reg     <= 1'b1;
            oe_reg      <= 1'b0;
            out_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            bit_reg     <= bit_next;
            byte_reg    <= byte_next;
            frame_reg   <= frame_next;
            step_reg    <= step_next;
            ack_err_reg <= ack_err_next;
            if (!busy || tick) div_reg <= '0;
            else               div_reg <= div_reg + 1'b1;
            if (accept) begin
                digits_reg <= digits;
                f3_reg     <= display_on ? {5'b10001, brightness} : 8'h80;
            end
            clk_reg <= clk_cmb;
            // When CLK falls, DIO waits one cycle so it only ever moves with CLK already low.
            if (!clk_reg || clk_cmb) begin
                oe_reg  <= oe_cmb;
                out_reg <= out_cmb;
            end
        end
    end

    assign ready          = (state_reg == S_IDLE);
    assign done           = (state_reg == S_DONE);
    assign ack_err        = ack_err_reg;
    assign tm1637_clk     = clk_reg;
    assign tm1637_dio_oe  = oe_reg;
    assign tm1637_dio_out = out_reg;
    assign tm1637_vcc     = 1'b1;
    assign debug_step_id  = step_reg;

endmodule
